// File: rtl/vr_rr_arbiter_pkg.sv
// Shared helpers for the valid/ready arbiter family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: id_width() sizes source-index fields, onehot_to_idx() encodes a one-hot grant.
package vr_arb_pkg;

  // Largest requester count the one-hot encoder accepts.
  localparam int MAX_N = 32;

  // Width of an index able to name n requesters (never narrower than 1 bit).
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index of the set bit of a one-hot vector; an all-zero vector yields 0.
  // ORing the indices avoids a priority chain when the input is truly one-hot.
  function automatic int onehot_to_idx(input logic [MAX_N-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/vr_rr_arbiter_if.sv
// Bundle of N producer channels plus the single arbitrated output channel.
// Latency: n/a (wiring only).
// Backpressure: in_ready per producer, out_ready from the consumer.
// Modports: slave = arbiter side, master = producers/consumer side.
interface vr_rr_arbiter_if import vr_arb_pkg::*; #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = id_width(N)
);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [IDW-1:0]     out_id;
  logic               out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_id
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_id
  );

endinterface

// File: rtl/vr_rr_arbiter_picker.sv
// Round-robin picker: first set request strictly after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; caller gates the grant with its own accept condition.
// Ports: req (requests), ptr (last winner) -> gnt_onehot, gnt_idx, gnt_any.
module rr_picker import vr_arb_pkg::*; #(
  parameter int N    = 4,
  localparam int IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt_onehot,
  output logic [IDW-1:0] gnt_idx,
  output logic           gnt_any
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] req_shift;
  logic [N-1:0]   rot;
  logic [N-1:0]   rot_first;
  int             pos;

  always_comb begin
    // Rotate so that requester ptr+1 lands at bit 0; doubling the vector
    // makes the wrap-around a plain right shift.
    req_dbl   = {req, req};
    req_shift = req_dbl >> (int'(ptr) + 1);
    rot       = req_shift[N-1:0];
    // Lowest set bit of the rotated vector is the round-robin winner.
    rot_first = rot & (~rot + N'(1));
    pos       = onehot_to_idx(MAX_N'(rot_first));
    // Undo the rotation to recover the absolute requester index.
    gnt_idx    = IDW'((pos + int'(ptr) + 1) % N);
    gnt_any    = |req;
    gnt_onehot = gnt_any ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/vr_rr_arbiter.sv
// N-to-1 round-robin arbiter with burst locking feeding one registered output stage.
// Latency: one cycle from an input handshake to out_valid; one beat per cycle.
// Backpressure: in_ready only when the stage is empty or draining; stall holds all state.
// Ports: clk, rst_n (async active-low), bus (slave side of vr_rr_arbiter_if).
module vr_rr_arbiter import vr_arb_pkg::*; #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 2,
  localparam int IDW      = id_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  vr_rr_arbiter_if.slave   bus
);

  localparam int CNTW = $clog2(MAX_BURST + 1);

  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  owner;
  logic [CNTW-1:0] burst_cnt;
  logic            lock;

  logic [N-1:0]    pick_onehot;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;

  logic            can_accept;
  logic            lock_hold;
  logic            xfer;
  logic [IDW-1:0]  grant;

  rr_picker #(.N(N)) u_picker (
    .req        (bus.in_valid),
    .ptr        (last_grant),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .gnt_any    (pick_any)
  );

  always_comb begin
    can_accept = !bus.out_valid || bus.out_ready;
    // The owner keeps the grant only while it still has beats and has not used up its burst.
    lock_hold  = lock && bus.in_valid[owner] && (burst_cnt < CNTW'(MAX_BURST));
    grant      = lock_hold ? owner : pick_idx;
    // Gating with rst_n keeps in_ready low for the whole reset, not just after the first edge.
    xfer       = pick_any && can_accept && rst_n;
    bus.in_ready = '0;
    if (xfer) begin
      bus.in_ready = lock_hold ? (N'(1) << owner) : pick_onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_id    <= '0;
      last_grant    <= IDW'(N - 1);
      owner         <= '0;
      burst_cnt     <= '0;
      lock          <= 1'b0;
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data[grant*WIDTH +: WIDTH];
      bus.out_id    <= grant;
      last_grant    <= grant;
      if (lock_hold) begin
        burst_cnt <= burst_cnt + CNTW'(1);
      end else begin
        // New owner, or the old owner re-granted after a full burst: start a fresh burst.
        owner     <= grant;
        burst_cnt <= CNTW'(1);
        lock      <= 1'b1;
      end
    end else begin
      if (bus.out_ready) bus.out_valid <= 1'b0;
      if (lock && !bus.in_valid[owner]) lock <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Bench for vr_rr_arbiter: instance a (MAX_BURST=2) and instance b (MAX_BURST=1).
// Inputs driven at posedge+1, everything sampled at negedge.
// A reference model predicts grants; a scoreboard queue per instance is checked by monitors.
module tb_vr_rr_arbiter;
  import vr_arb_pkg::*;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = id_width(N);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   dat;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vr_rr_arbiter_if #(.N(N), .WIDTH(W)) ifa ();
  vr_rr_arbiter_if #(.N(N), .WIDTH(W)) ifb ();

  vr_rr_arbiter #(.N(N), .WIDTH(W), .MAX_BURST(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  vr_rr_arbiter #(.N(N), .WIDTH(W), .MAX_BURST(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, indexed by instance.
  int m_last [2];
  int m_owner[2];
  int m_cnt  [2];
  bit m_lock [2];
  bit m_ov   [2];

  beat_t sbq0[$];
  beat_t sbq1[$];
  int    obs_a[$];
  int    obs_b[$];
  int    sent[2][N];
  int    rcvd[2][N];
  beat_t ea, eb;

  int exp2[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  int exp5[4]  = '{0, 3, 3, 0};
  int exp6[4]  = '{0, 2, 0, 2};

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] get_valid(int inst);
    return (inst == 0) ? ifa.in_valid : ifb.in_valid;
  endfunction
  function automatic logic [N-1:0] get_ready(int inst);
    return (inst == 0) ? ifa.in_ready : ifb.in_ready;
  endfunction
  function automatic logic get_ov(int inst);
    return (inst == 0) ? ifa.out_valid : ifb.out_valid;
  endfunction
  function automatic logic get_ordy(int inst);
    return (inst == 0) ? ifa.out_ready : ifb.out_ready;
  endfunction
  function automatic logic [W-1:0] get_dat(int inst, int g);
    return (inst == 0) ? ifa.in_data[g*W +: W] : ifb.in_data[g*W +: W];
  endfunction

  task automatic set_valid(int inst, int i, logic v);
    if (inst == 0) ifa.in_valid[i] = v; else ifb.in_valid[i] = v;
  endtask
  task automatic set_dat(int inst, int i, logic [W-1:0] d);
    if (inst == 0) ifa.in_data[i*W +: W] = d; else ifb.in_data[i*W +: W] = d;
  endtask
  task automatic set_ordy(int inst, logic v);
    if (inst == 0) ifa.out_ready = v; else ifb.out_ready = v;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last[k] = N - 1; m_owner[k] = 0; m_cnt[k] = 0; m_lock[k] = 0; m_ov[k] = 0;
      for (int i = 0; i < N; i++) begin sent[k][i] = 0; rcvd[k][i] = 0; end
    end
    sbq0.delete();
    sbq1.delete();
  endtask

  // Who should win this cycle: the locked owner while its burst lasts, else the
  // first valid requester after the last winner, going around the ring.
  function automatic int model_pick(int inst, logic [N-1:0] v, int mb);
    if (v == '0) return -1;
    if (m_lock[inst] && v[m_owner[inst]] && m_cnt[inst] < mb) return m_owner[inst];
    for (int k = 1; k <= N; k++) begin
      if (v[(m_last[inst] + k) % N]) return (m_last[inst] + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle on an instance: check in_ready/out_valid against the model,
  // record the predicted output beat, advance the model, retire the accepted beat.
  task automatic step(int inst);
    logic [N-1:0] v, rdy, exp_rdy;
    logic         ordy, ov;
    logic [W-1:0] d;
    int           g, mb;
    bit           acc;
    string        pfx;
    @(negedge clk);
    pfx  = (inst == 0) ? "a" : "b";
    mb   = (inst == 0) ? 2 : 1;
    v    = get_valid(inst);
    rdy  = get_ready(inst);
    ordy = get_ordy(inst);
    ov   = get_ov(inst);
    check($sformatf("%s_out_valid", pfx), int'(ov), int'(m_ov[inst]));
    acc     = !m_ov[inst] || ordy;
    g       = model_pick(inst, v, mb);
    exp_rdy = (g >= 0 && acc) ? (N'(1) << g) : '0;
    check($sformatf("%s_in_ready", pfx), int'(rdy), int'(exp_rdy));
    if (g >= 0 && acc) begin
      d = get_dat(inst, g);
      if (inst == 0) sbq0.push_back(beat_t'{id: IDW'(g), dat: d});
      else           sbq1.push_back(beat_t'{id: IDW'(g), dat: d});
      sent[inst][g]++;
      if (m_lock[inst] && g == m_owner[inst] && m_cnt[inst] < mb) begin
        m_cnt[inst]++;
      end else begin
        m_owner[inst] = g; m_cnt[inst] = 1; m_lock[inst] = 1;
      end
      m_last[inst] = g;
      m_ov[inst]   = 1;
    end else begin
      if (m_ov[inst] && ordy) m_ov[inst] = 0;
      if (m_lock[inst] && !v[m_owner[inst]]) m_lock[inst] = 0;
    end
    @(posedge clk);
    #1;
    if (g >= 0 && acc) set_valid(inst, g, 1'b0);
  endtask

  // Producers that are idle may present a new beat; a presented beat is held until taken.
  task automatic rand_drive(int inst, logic [N-1:0] mask, int pct, int rdy_pct, bit fixdat);
    logic [N-1:0] v;
    v = get_valid(inst);
    for (int i = 0; i < N; i++) begin
      if (mask[i] && !v[i] && int'($urandom_range(99)) < pct) begin
        set_valid(inst, i, 1'b1);
        set_dat(inst, i, fixdat ? W'(8'h10 + i) : W'($urandom));
      end
    end
    set_ordy(inst, int'($urandom_range(99)) < rdy_pct);
  endtask

  task automatic drain(int inst, int cycles);
    set_ordy(inst, 1'b1);
    for (int k = 0; k < cycles; k++) step(inst);
  endtask

  always @(negedge clk) begin
    if (rst_n && ifa.out_valid && ifa.out_ready) begin
      if (sbq0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_extra_beat: got id %0d data %0h, expected no beat", ifa.out_id, ifa.out_data);
      end else begin
        ea = sbq0.pop_front();
        check("a_out_id", int'(ifa.out_id), int'(ea.id));
        check("a_out_data", int'(ifa.out_data), int'(ea.dat));
        obs_a.push_back(int'(ifa.out_id));
        rcvd[0][ifa.out_id]++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ifb.out_valid && ifb.out_ready) begin
      if (sbq1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_extra_beat: got id %0d data %0h, expected no beat", ifb.out_id, ifb.out_data);
      end else begin
        eb = sbq1.pop_front();
        check("b_out_id", int'(ifb.out_id), int'(eb.id));
        check("b_out_data", int'(ifb.out_data), int'(eb.dat));
        obs_b.push_back(int'(ifb.out_id));
        rcvd[1][ifb.out_id]++;
      end
    end
  end

  initial begin
    ifa.in_valid = '0; ifa.in_data = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = '0; ifb.in_data = '0; ifb.out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid", int'(ifa.out_valid), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // All four producers always valid: bursts of two rotating 0..3.
    obs_a.delete();
    for (int k = 0; k < 12; k++) begin
      rand_drive(0, 4'hF, 100, 100, 1'b1);
      step(0);
    end
    drain(0, 8);
    check("seq_all4_len_ok", int'(obs_a.size() >= 10), 1);
    for (int k = 0; k < 10 && k < obs_a.size(); k++)
      check($sformatf("seq_all4_%0d", k), obs_a[k], exp2[k]);

    // Only requester 2: back-to-back beats, bursts restart.
    obs_a.delete();
    for (int k = 0; k < 5; k++) begin
      rand_drive(0, 4'b0100, 100, 100, 1'b0);
      step(0);
    end
    drain(0, 3);
    check("solo2_len", obs_a.size(), 5);
    for (int k = 0; k < obs_a.size(); k++)
      check($sformatf("solo2_id_%0d", k), obs_a[k], 2);

    // Stall with A5 held, then drain and refill in one cycle.
    set_valid(0, 1, 1'b1); set_dat(0, 1, 8'hA5); set_ordy(0, 1'b0);
    step(0);
    set_valid(0, 1, 1'b1); set_dat(0, 1, 8'h5A);
    for (int k = 0; k < 3; k++) begin
      step(0);
      check($sformatf("stall_data_%0d", k), int'(ifa.out_data), 'hA5);
      check($sformatf("stall_id_%0d", k), int'(ifa.out_id), 1);
    end
    set_ordy(0, 1'b1);
    step(0);
    check("refill_data", int'(ifa.out_data), 'h5A);
    check("refill_valid", int'(ifa.out_valid), 1);
    drain(0, 3);

    // Owner 0 drops valid after one beat; lock moves to requester 3.
    obs_a.delete();
    set_valid(0, 0, 1'b1); set_dat(0, 0, 8'h50);
    step(0);
    set_valid(0, 3, 1'b1); set_dat(0, 3, 8'h53);
    step(0);
    set_valid(0, 0, 1'b1); set_dat(0, 0, 8'h60);
    set_valid(0, 3, 1'b1); set_dat(0, 3, 8'h63);
    step(0);
    step(0);
    drain(0, 3);
    check("lockmove_len", obs_a.size(), 4);
    for (int k = 0; k < 4 && k < obs_a.size(); k++)
      check($sformatf("lockmove_%0d", k), obs_a[k], exp5[k]);

    // Random traffic with random backpressure.
    for (int k = 0; k < 300; k++) begin
      rand_drive(0, 4'hF, 40, 70, 1'b0);
      step(0);
    end

    // Reset while a beat sits in the output stage.
    for (int i = 0; i < N; i++) begin set_valid(0, i, 1'b1); set_dat(0, i, W'(8'h20 + i)); end
    set_ordy(0, 1'b0);
    step(0);
    check("pre_rst_out_valid", int'(ifa.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_out_valid", int'(ifa.out_valid), 0);
    check("rst_async_in_ready", int'(ifa.in_ready), 0);
    check("rst_async_out_data", int'(ifa.out_data), 0);
    check("rst_async_out_id", int'(ifa.out_id), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    obs_a.delete();
    set_ordy(0, 1'b1);
    step(0);
    step(0);
    check("post_rst_seen", int'(obs_a.size() >= 1), 1);
    if (obs_a.size() >= 1) check("post_rst_first_id", obs_a[0], 0);
    drain(0, 8);

    // MAX_BURST=1: two steady requesters alternate.
    obs_b.delete();
    for (int k = 0; k < 8; k++) begin
      rand_drive(1, 4'b0101, 100, 100, 1'b0);
      step(1);
    end
    drain(1, 4);
    check("rr1_len_ok", int'(obs_b.size() >= 4), 1);
    for (int k = 0; k < 4 && k < obs_b.size(); k++)
      check($sformatf("rr1_%0d", k), obs_b[k], exp6[k]);

    for (int k = 0; k < 300; k++) begin
      rand_drive(1, 4'hF, 50, 70, 1'b0);
      step(1);
    end
    drain(1, 10);

    check("a_queue_empty", sbq0.size(), 0);
    check("b_queue_empty", sbq1.size(), 0);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++)
        check($sformatf("beats_%0d_src%0d", k, i), rcvd[k][i], sent[k][i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
